// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and byte-lane helper for the data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    COMMIT = 2'b10,
    RESP   = 2'b11
  } state_t;

  // Half accesses only look at off[1], word accesses ignore off, so silent alignment falls out here.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: store enables/replication and load extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext
);

  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_ext;
  logic signed [31:0] half_ext;

  always_comb begin
    be       = lane_mask(size, off);
    wword    = '0;
    rext     = '0;
    shifted  = '0;
    byte_s   = '0;
    half_s   = '0;
    byte_ext = '0;
    half_ext = '0;
    case (size)
      SZ_BYTE: begin
        wword    = {4{wdata[7:0]}};
        shifted  = rword >> {off, 3'b000};
        byte_s   = shifted[7:0];
        byte_ext = byte_s;
        rext     = sign_ext ? byte_ext : {24'd0, shifted[7:0]};
      end
      SZ_HALF: begin
        wword    = {2{wdata[15:0]}};
        shifted  = off[1] ? {16'd0, rword[31:16]} : rword;
        half_s   = shifted[15:0];
        half_ext = half_s;
        rext     = sign_ext ? half_ext : {16'd0, shifted[15:0]};
      end
      SZ_WORD: begin
        wword = wdata;
        rext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-organised data RAM behind a req/done handshake with wait states and a debug write window.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of silently aligning them.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 2048,
  parameter int AW          = $clog2(DEPTH) + 2,
  parameter int WAIT_STATES = 0,
  parameter int DBG_BASE    = 1024,
  parameter int DBG_ENTRIES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           we,
  input  logic [1:0]                     size,
  input  logic                           sign_ext,
  input  logic [AW-1:0]                  addr,
  input  logic [31:0]                    wdata,
  output logic                           done,
  output logic [31:0]                    rdata,
  output logic                           err,
  output logic                           busy,
  input  logic                           dbg_we,
  input  logic [$clog2(DBG_ENTRIES)-1:0] dbg_addr,
  input  logic [31:0]                    dbg_wdata
);

  localparam int          IW        = AW - 2;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state, state_nxt;
  logic [3:0]    wcnt;
  logic          req_armed;
  logic          accept, commit_go;
  logic          l_we, l_sext;
  logic [1:0]    l_size;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;
  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] widx, dbg_idx;
  logic          range_err, size_err, align_err, acc_err;
  logic [3:0]    be;
  logic [31:0]   wword, rword, rext;

  assign widx      = l_addr[AW-1:2];
  assign dbg_idx   = IW'(DBG_BASE) + IW'(dbg_addr);
  assign range_err = {{(32-IW){1'b0}}, widx} >= DEPTH_W;
  assign size_err  = (l_size == SZ_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_err = ((l_size == SZ_HALF) && l_addr[0]) ||
                     ((l_size == SZ_WORD) && (l_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign acc_err   = range_err | size_err | align_err;
  assign rword     = range_err ? 32'd0 : mem[widx];

  // A debug write in COMMIT pushes the CPU access back a cycle so debug data is visible/overwritten
  assign accept    = (state == IDLE) && req && req_armed && !done;
  assign commit_go = (state == COMMIT) && !dbg_we;
  assign busy      = (state != IDLE);

  dmem_lane_align u_align (
    .size     (l_size),
    .off      (l_addr[1:0]),
    .sign_ext (l_sext),
    .wdata    (l_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rext     (rext)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) state_nxt = WAIT;
          else                 state_nxt = COMMIT;
        end
      end
      WAIT:    if (wcnt == 4'd0) state_nxt = COMMIT;
      COMMIT:  if (!dbg_we) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      req_armed <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      state <= state_nxt;
      done  <= commit_go;
      if (!req)        req_armed <= 1'b1;
      else if (accept) req_armed <= 1'b0;
      if (accept)                            wcnt <= WCNT_INIT;
      else if (state == WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
      if (commit_go) begin
        err   <= acc_err;
        rdata <= (acc_err || l_we) ? 32'd0 : rext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= we;
      l_size  <= size;
      l_sext  <= sign_ext;
      l_addr  <= addr;
      l_wdata <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (dbg_we) mem[dbg_idx] <= dbg_wdata;
    if (commit_go && l_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table plus debug-deferral and reset-abort sequences.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH       = 1536;
  localparam int WS          = 3;
  localparam int DBG_BASE    = 1024;
  localparam int DBG_ENTRIES = 32;
  localparam int AW          = $clog2(DEPTH) + 2;
  localparam int DBW         = $clog2(DBG_ENTRIES);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, req, we, sign_ext, done, err, busy, dbg_we;
  logic [1:0]     size;
  logic [AW-1:0]  addr;
  logic [31:0]    wdata, rdata, dbg_wdata;
  logic [DBW-1:0] dbg_addr;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        er;
    logic        chk_rd;
    int          lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  dmem_ctrl #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS),
    .DBG_BASE    (DBG_BASE),
    .DBG_ENTRIES (DBG_ENTRIES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input bit w, input logic [1:0] sz, input bit sx,
                              input int a, input logic [31:0] d, input logic [31:0] rd,
                              input bit er, input bit crd);
    vec_t v;
    v.nm = nm; v.w = w; v.sz = sz; v.sx = sx; v.a = AW'(a); v.d = d;
    v.exp_rd = rd; v.exp_err = er; v.chk_rd = crd;
    return v;
  endfunction

  task automatic start_req(input vec_t v, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = v.w; size = v.sz; sign_ext = v.sx; addr = v.a; wdata = v.d;
    if (push) begin
      e.nm = v.nm; e.rd = v.exp_rd; e.er = v.exp_err; e.chk_rd = v.chk_rd; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic wait_done();
    exp_t e;
    int   lat;
    bit   busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && lat < 40);
    e = sb.pop_front();
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1 after %0d", e.nm, lat, e.lat);
      req = 1'b0;
    end else begin
      check({e.nm, "_lat"}, 32'(lat), 32'(e.lat));
      check({e.nm, "_err"}, 32'(err), 32'(e.er));
      if (e.chk_rd) check({e.nm, "_rdata"}, rdata, e.rd);
      check({e.nm, "_busy_during"}, 32'(busy_ok & busy), 32'd1);
      req = 1'b0;
      @(negedge clk);
      check({e.nm, "_done_pulse"}, 32'(done), 32'd0);
      check({e.nm, "_busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run(input vec_t v, input int lat);
    start_req(v, lat, 1'b1);
    wait_done();
  endtask

  task automatic dbg_pulse_in_commit(input logic [DBW-1:0] da, input logic [31:0] dd);
    fork
      begin
        repeat (WS) @(posedge clk);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = da; dbg_wdata = dd;
        @(negedge clk);
        dbg_we = 1'b0;
      end
    join_none
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = '0; wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    tbl.push_back(mk("st_w_deadbeef", 1, SZ_WORD, 0, 'h10, 32'hDEADBEEF, 32'h0, 0, 0));
    tbl.push_back(mk("ld_b13_sx1",    0, SZ_BYTE, 1, 'h13, 32'h0, 32'hFFFFFFDE, 0, 1));
    tbl.push_back(mk("ld_b13_sx0",    0, SZ_BYTE, 0, 'h13, 32'h0, 32'h000000DE, 0, 1));
    tbl.push_back(mk("ld_b11_sx1",    0, SZ_BYTE, 1, 'h11, 32'h0, 32'hFFFFFFBE, 0, 1));
    tbl.push_back(mk("ld_b10_sx0",    0, SZ_BYTE, 0, 'h10, 32'h0, 32'h000000EF, 0, 1));
    tbl.push_back(mk("st_w_aabbccdd", 1, SZ_WORD, 0, 'h20, 32'hAABBCCDD, 32'h0, 0, 0));
    tbl.push_back(mk("st_h22_1234",   1, SZ_HALF, 0, 'h22, 32'h00001234, 32'h0, 0, 0));
    tbl.push_back(mk("ld_w20",        0, SZ_WORD, 1, 'h20, 32'h0, 32'h1234CCDD, 0, 1));
    tbl.push_back(mk("ld_h20_sx1",    0, SZ_HALF, 1, 'h20, 32'h0, 32'hFFFFCCDD, 0, 1));
    tbl.push_back(mk("ld_h22_sx1",    0, SZ_HALF, 1, 'h22, 32'h0, 32'h00001234, 0, 1));
    tbl.push_back(mk("st_b12_5a",     1, SZ_BYTE, 0, 'h12, 32'h0000005A, 32'h0, 0, 0));
    tbl.push_back(mk("ld_w10_merge",  0, SZ_WORD, 0, 'h10, 32'h0, 32'hDE5ABEEF, 0, 1));
    tbl.push_back(mk("ld_rsvd",       0, SZ_RSVD, 0, 'h10, 32'h0, 32'h0, 1, 1));
    tbl.push_back(mk("st_rsvd",       1, SZ_RSVD, 0, 'h10, 32'hFFFFFFFF, 32'h0, 1, 1));
    tbl.push_back(mk("ld_w10_kept",   0, SZ_WORD, 0, 'h10, 32'h0, 32'hDE5ABEEF, 0, 1));
    tbl.push_back(mk("ld_oob",        0, SZ_WORD, 0, 'h1800, 32'h0, 32'h0, 1, 1));
    tbl.push_back(mk("st_oob",        1, SZ_WORD, 0, 'h1800, 32'h12345678, 32'h0, 1, 1));
    tbl.push_back(mk("st_w0",         1, SZ_WORD, 0, 'h0, 32'h11223344, 32'h0, 0, 0));
    tbl.push_back(mk("st_w02_misal",  1, SZ_WORD, 0, 'h2, 32'h99887766, 32'h0, TRAP, TRAP));
    tbl.push_back(mk("ld_w0_after",   0, SZ_WORD, 0, 'h0, 32'h0,
                     TRAP ? 32'h11223344 : 32'h99887766, 0, 1));
    tbl.push_back(mk("ld_h23_misal",  0, SZ_HALF, 0, 'h23, 32'h0,
                     TRAP ? 32'h0 : 32'h00001234, TRAP, 1));
    tbl.push_back(mk("ld_h21_misal",  0, SZ_HALF, 1, 'h21, 32'h0,
                     TRAP ? 32'h0 : 32'hFFFFCCDD, TRAP, 1));

    repeat (3) @(negedge clk);
    check("reset_done",  32'(done), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_err",   32'(err),  32'd0);
    check("reset_rdata", rdata,     32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], WS + 2);

    // Debug write colliding with a CPU store to the same word: store lands last, done slips a cycle
    start_req(mk("dbg_collide_st", 1, SZ_WORD, 0, 'h1014, 32'h00000077, 32'h0, 0, 0), WS + 3, 1'b1);
    dbg_pulse_in_commit(DBW'(5), 32'h00000055);
    wait_done();
    run(mk("ld_1029", 0, SZ_WORD, 0, 'h1014, 32'h0, 32'h00000077, 0, 1), WS + 2);

    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = DBW'(6); dbg_wdata = 32'h00000055;
    @(negedge clk);
    dbg_we = 1'b0;
    run(mk("ld_dbg_only", 0, SZ_WORD, 0, 'h1018, 32'h0, 32'h00000055, 0, 1), WS + 2);

    run(mk("st_1031", 1, SZ_WORD, 0, 'h101C, 32'hAAAAAAAA, 32'h0, 0, 0), WS + 2);
    start_req(mk("dbg_collide_ld", 0, SZ_WORD, 0, 'h101C, 32'h0, 32'h00000099, 0, 1), WS + 3, 1'b1);
    dbg_pulse_in_commit(DBW'(7), 32'h00000099);
    wait_done();

    // Reset while a store sits in WAIT: the store is dropped and no done appears
    run(mk("st_w50", 1, SZ_WORD, 0, 'hC8, 32'hCAFEF00D, 32'h0, 0, 0), WS + 2);
    run(mk("ld_w50", 0, SZ_WORD, 0, 'hC8, 32'h0, 32'hCAFEF00D, 0, 1), WS + 2);
    start_req(mk("st_w50_abort", 1, SZ_WORD, 0, 'hC8, 32'h12345678, 32'h0, 0, 0), WS + 2, 1'b0);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_done",  32'(done), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_err",   32'(err),  32'd0);
    check("abort_rdata", rdata,     32'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle",    32'(busy),      32'd0);
    run(mk("ld_w50_kept", 0, SZ_WORD, 0, 'hC8, 32'h0, 32'hCAFEF00D, 0, 1), WS + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
